// File: rtl/sha1_msg_padder.sv
`default_nettype none
// ============================================================================
// Module   : sha1_msg_padder
// Purpose  : Packs a byte stream into big-endian 512-bit SHA-1 blocks and
//            appends 0x80, zero fill and the 64-bit message bit length.
// Revision : 1.0 - initial release
// ============================================================================
module sha1_msg_padder #(
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] block,
    output logic         block_valid,
    output logic         block_first,
    output logic         block_last,
    input  logic         block_ready
);

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_PAD  = 2'd1;
    localparam logic [1:0] ST_LEN  = 2'd2;
    localparam logic [1:0] ST_EMIT = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [1:0]       resume;
    logic [5:0]       idx;
    logic [CNT_W-1:0] byte_cnt;
    logic [511:0]     buffer;
    logic             first_flag;
    logic             final_flag;
    logic [8:0]       bit_hi;
    logic [63:0]      len_bits;

    assign bit_hi   = 9'd511 - {idx, 3'b000};
    assign len_bits = 64'({byte_cnt, 3'b000});
    assign block    = buffer;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL: begin
                if (in_valid) begin
                    if (idx == 6'd63)  state_nxt = ST_EMIT;
                    else if (in_last)  state_nxt = ST_PAD;
                end
            end
            ST_PAD:  state_nxt = (idx <= 6'd55) ? ST_LEN : ST_EMIT;
            ST_LEN:  state_nxt = ST_EMIT;
            default: begin
                if (block_ready) state_nxt = final_flag ? ST_FILL : resume;
            end
        endcase
    end

    always_comb begin
        in_ready    = (state == ST_FILL);
        block_valid = (state == ST_EMIT);
        block_first = first_flag & block_valid;
        block_last  = final_flag & block_valid;
    end

    // The buffer is cleared on every hand-off, so zero fill needs no cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx        <= 6'd0;
            byte_cnt   <= '0;
            buffer     <= '0;
            first_flag <= 1'b1;
            final_flag <= 1'b0;
            resume     <= ST_FILL;
        end else begin
            case (state)
                ST_FILL: begin
                    if (in_valid) begin
                        buffer[bit_hi -: 8] <= in_data;
                        byte_cnt            <= byte_cnt + CNT_W'(1);
                        if (idx != 6'd63) idx    <= idx + 6'd1;
                        else              resume <= in_last ? ST_PAD : ST_FILL;
                    end
                end
                ST_PAD: begin
                    buffer[bit_hi -: 8] <= 8'h80;
                    if (idx > 6'd55) resume <= ST_LEN;
                end
                ST_LEN: begin
                    buffer[63:0] <= len_bits;
                    final_flag   <= 1'b1;
                end
                default: begin
                    if (block_ready) begin
                        buffer     <= '0;
                        idx        <= 6'd0;
                        first_flag <= final_flag;
                        if (final_flag) begin
                            byte_cnt   <= '0;
                            final_flag <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha1_msg_padder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha1_msg_padder
// Purpose  : Scoreboard bench for sha1_msg_padder against a padding model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha1_msg_padder;

    logic         clk;
    logic         reset_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] block;
    logic         block_valid;
    logic         block_first;
    logic         block_last;
    logic         block_ready;

    sha1_msg_padder #(.CNT_W(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .block       (block),
        .block_valid (block_valid),
        .block_first (block_first),
        .block_last  (block_last),
        .block_ready (block_ready)
    );

    typedef struct packed {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] cur_msg[$];
    int         checks = 0;
    int         errors = 0;
    int         ready_mode = 1;   // 0 random, 1 always ready, 2 stalled
    bit         msg2_done = 0;
    logic [511:0] abc_blk;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        block_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       block_ready = 1'($urandom_range(0, 1));
                1:       block_ready = 1'b1;
                default: block_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
    task automatic push_model();
        logic [7:0]  p[$];
        logic [63:0] bitlen;
        exp_t        e;
        int          nblk;
        p = cur_msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bitlen = 64'(cur_msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            e.blk = '0;
            for (int i = 0; i < 64; i++) e.blk[511 - 8*i -: 8] = p[64*b + i];
            e.first = (b == 0);
            e.last  = (b == nblk - 1);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && block_valid && block_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_block: got %0h expected none", block);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("block_data", block, e.blk);
                chk("block_first", 512'(block_first), 512'(e.first));
                chk("block_last", 512'(block_last), 512'(e.last));
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit last);
        int t;
        bit acc;
        t = 0;
        acc = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        while (!acc && t < 3000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: got no in_ready expected in_ready within 3000 cycles");
        end
    endtask

    // with_model=0 sends cur_msg without a last flag and expects nothing.
    task automatic send_msg(input bit with_model, input bit gaps);
        if (with_model) push_model();
        for (int i = 0; i < cur_msg.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_byte(cur_msg[i], with_model && (i == cur_msg.size() - 1));
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d blocks outstanding expected 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic load_abc();
        cur_msg = {8'h61, 8'h62, 8'h63};
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 512'(in_ready), 512'(1'b1));
        chk({tag, "_block_valid"}, 512'(block_valid), 512'(1'b0));
        chk({tag, "_block_first"}, 512'(block_first), 512'(1'b0));
        chk({tag, "_block_last"}, 512'(block_last), 512'(1'b0));
        chk({tag, "_block"}, block, 512'(0));
    endtask

    initial begin
        abc_blk  = {32'h61626380, 416'h0, 64'h18};
        in_data  = 8'h00;
        in_valid = 1'b0;
        in_last  = 1'b0;
        reset_n  = 1'b1;
        #2 reset_n = 1'b0;
        #2 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // "abc" with exact output latency
        ready_mode = 1;
        load_abc();
        send_msg(1, 0);
        @(negedge clk); chk("lat_k1_valid", 512'(block_valid), 512'(1'b0));
        @(negedge clk); chk("lat_k2_valid", 512'(block_valid), 512'(1'b0));
        @(negedge clk); chk("lat_k3_valid", 512'(block_valid), 512'(1'b1));
        chk("abc_block", block, abc_blk);
        drain();

        cur_msg = {};
        repeat (55) cur_msg.push_back(8'h00);
        send_msg(1, 0);
        drain();

        cur_msg = {};
        repeat (56) cur_msg.push_back(8'hFF);
        send_msg(1, 0);
        drain();

        cur_msg = {};
        for (int i = 0; i < 64; i++) cur_msg.push_back(8'(i));
        send_msg(1, 0);
        drain();

        // Backpressure: block held, second message must wait
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        load_abc();
        send_msg(1, 0);
        begin
            int t;
            t = 0;
            while (!block_valid && t < 20) begin @(negedge clk); t++; end
        end
        cur_msg = {8'h11, 8'h22, 8'h33, 8'h44};
        fork
            begin
                send_msg(1, 0);
                msg2_done = 1'b1;
            end
        join_none
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", 512'(block_valid), 512'(1'b1));
            chk("stall_in_ready", 512'(in_ready), 512'(1'b0));
            chk("stall_block", block, abc_blk);
        end
        ready_mode = 1;
        begin
            int t;
            t = 0;
            while (!msg2_done && t < 200) begin @(negedge clk); t++; end
            checks++;
            if (!msg2_done) begin
                errors++;
                $display("FAIL msg2_send: got incomplete expected sent");
            end
        end
        drain();

        // Reset after 30 bytes of an unterminated message
        cur_msg = {};
        repeat (30) cur_msg.push_back(8'($urandom));
        send_msg(0, 0);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        load_abc();
        send_msg(1, 0);
        drain();

        // Random messages under random backpressure and input gaps
        ready_mode = 0;
        for (int m = 0; m < 15; m++) begin
            int len;
            len = $urandom_range(1, 140);
            cur_msg = {};
            for (int i = 0; i < len; i++) cur_msg.push_back(8'($urandom));
            send_msg(1, 1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
